// File: rtl/fsm_3.sv
// Coin-accumulating vending controller for a 4-yuan item.
// One-segment Moore FSM over one-hot credit states with registered dispense outputs.
module fsm_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] in,
    output logic [1:0] out,
    output logic       out_vld
);

    typedef enum logic [3:0] {
        S0 = 4'b0001,
        S1 = 4'b0010,
        S2 = 4'b0100,
        S3 = 4'b1000
    } state_t;

    localparam logic [1:0] CoinOne = 2'd1;
    localparam logic [1:0] CoinTwo = 2'd2;

    state_t state;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= S0;
            out     <= 2'd0;
            out_vld <= 1'b0;
        end else begin
            out     <= 2'd0;
            out_vld <= 1'b0;
            case (state)
                S0: begin
                    if (in == CoinOne) begin
                        state <= S1;
                    end else if (in == CoinTwo) begin
                        state <= S2;
                    end
                end
                S1: begin
                    if (in == CoinOne) begin
                        state <= S2;
                    end else if (in == CoinTwo) begin
                        state <= S3;
                    end
                end
                S2: begin
                    if (in == CoinOne) begin
                        state <= S3;
                    end else if (in == CoinTwo) begin
                        state   <= S0;
                        out_vld <= 1'b1;
                    end
                end
                S3: begin
                    if (in == CoinOne) begin
                        state   <= S0;
                        out_vld <= 1'b1;
                    end else if (in == CoinTwo) begin
                        state   <= S0;
                        out_vld <= 1'b1;
                        out     <= 2'd1;
                    end
                end
                // Non-one-hot state recovers to S0 without dispensing.
                default: state <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_3.sv
// Directed self-checking bench for fsm_3: coin sequences, dispense pulses, reset and invalid input.
module tb_fsm_3;

    logic       clk;
    logic       rst_n;
    logic [1:0] in;
    logic [1:0] out;
    logic       out_vld;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [3:0] S0 = 4'b0001;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S3 = 4'b1000;

    fsm_3 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .out     (out),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present v for one edge, then check at the next negedge.
    task automatic step(input string tag, input logic [1:0] v, input logic [3:0] exp_state,
                        input logic exp_vld, input logic [1:0] exp_out);
        in = v;
        @(negedge clk);
        chk({tag, ".state"}, {4'd0, dut.state}, {4'd0, exp_state});
        chk({tag, ".vld"}, {7'd0, out_vld}, {7'd0, exp_vld});
        chk({tag, ".out"}, {6'd0, out}, {6'd0, exp_out});
    endtask

    initial begin
        rst_n = 1'b1;
        in    = 2'd0;
        @(negedge clk);

        // 1: reset held 20 cycles, then release
        for (int i = 0; i < 20; i++) begin
            step("rst_hold", 2'd0, S0, 1'b0, 2'd0);
        end
        rst_n = 1'b0;
        step("rst_rel", 2'd0, S0, 1'b0, 2'd0);
        step("rst_rel2", 2'd0, S0, 1'b0, 2'd0);

        // 2: 1,1,1,1 with idle gaps
        step("t2_c1", 2'd1, S1, 1'b0, 2'd0);
        step("t2_i1", 2'd0, S1, 1'b0, 2'd0);
        step("t2_c2", 2'd1, S2, 1'b0, 2'd0);
        step("t2_i2", 2'd0, S2, 1'b0, 2'd0);
        step("t2_c3", 2'd1, S3, 1'b0, 2'd0);
        step("t2_i3", 2'd0, S3, 1'b0, 2'd0);
        step("t2_c4", 2'd1, S0, 1'b1, 2'd0);
        step("t2_i4", 2'd0, S0, 1'b0, 2'd0);
        step("t2_i5", 2'd0, S0, 1'b0, 2'd0);

        // 3: 1,1,1,2 -> change 1
        step("t3_c1", 2'd1, S1, 1'b0, 2'd0);
        step("t3_c2", 2'd1, S2, 1'b0, 2'd0);
        step("t3_c3", 2'd1, S3, 1'b0, 2'd0);
        step("t3_c4", 2'd2, S0, 1'b1, 2'd1);
        step("t3_i", 2'd0, S0, 1'b0, 2'd0);

        // 4: 1,1,2 -> change 0; 1,2,2 -> change 1
        step("t4a_c1", 2'd1, S1, 1'b0, 2'd0);
        step("t4a_c2", 2'd1, S2, 1'b0, 2'd0);
        step("t4a_c3", 2'd2, S0, 1'b1, 2'd0);
        step("t4a_i", 2'd0, S0, 1'b0, 2'd0);
        step("t4b_c1", 2'd1, S1, 1'b0, 2'd0);
        step("t4b_c2", 2'd2, S3, 1'b0, 2'd0);
        step("t4b_c3", 2'd2, S0, 1'b1, 2'd1);
        step("t4b_i", 2'd0, S0, 1'b0, 2'd0);

        // 5: 2,idle,2 then back-to-back 2,2
        step("t5a_c1", 2'd2, S2, 1'b0, 2'd0);
        step("t5a_i", 2'd0, S2, 1'b0, 2'd0);
        step("t5a_c2", 2'd2, S0, 1'b1, 2'd0);
        step("t5a_i2", 2'd0, S0, 1'b0, 2'd0);
        step("t5b_c1", 2'd2, S2, 1'b0, 2'd0);
        step("t5b_c2", 2'd2, S0, 1'b1, 2'd0);
        step("t5b_i", 2'd0, S0, 1'b0, 2'd0);

        // Coin presented while the dispense pulse is visible starts from S0
        step("ovl_c1", 2'd2, S2, 1'b0, 2'd0);
        step("ovl_c2", 2'd2, S0, 1'b1, 2'd0);
        step("ovl_c3", 2'd1, S1, 1'b0, 2'd0);
        step("ovl_c4", 2'd2, S3, 1'b0, 2'd0);
        step("ovl_c5", 2'd1, S0, 1'b1, 2'd0);
        step("ovl_i", 2'd0, S0, 1'b0, 2'd0);

        // Invalid coin holds mid-transaction
        step("inv_c1", 2'd2, S2, 1'b0, 2'd0);
        step("inv_x", 2'd3, S2, 1'b0, 2'd0);
        step("inv_c2", 2'd2, S0, 1'b1, 2'd0);
        step("inv_i", 2'd0, S0, 1'b0, 2'd0);

        // 6: reach S3, reset overrides a coin in the same cycle, then invalid input
        step("t6_c1", 2'd1, S1, 1'b0, 2'd0);
        step("t6_c2", 2'd2, S3, 1'b0, 2'd0);
        rst_n = 1'b1;
        step("t6_rst", 2'd2, S0, 1'b0, 2'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("t6_inv", 2'd3, S0, 1'b0, 2'd0);
        end
        step("t6_i", 2'd0, S0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
